// File: rtl/dac_tx_pkg.sv
// Shared definitions for the MCP4921-style serial DAC transmitter:
// frame geometry, command-nibble layout and FSM state encoding.
package dac_tx_pkg;

  // One SPI command frame: 4-bit config nibble followed by a 12-bit sample.
  localparam int FRAME_W = 16;

  // Command nibble bit positions within the 16-bit frame.
  localparam int CFG_AB_BIT   = 15;  // 0 = DAC A
  localparam int CFG_BUF_BIT  = 14;  // 0 = unbuffered Vref
  localparam int CFG_GA_BIT   = 13;  // 1 = 1x gain
  localparam int CFG_SHDN_BIT = 12;  // 1 = output active

  // Default nibble: DAC A, unbuffered, 1x gain, active.
  localparam logic [3:0] CFG_DEFAULT = 4'b0011;

  // FSM state encoding.
  localparam int         STATE_W  = 3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/dac_tx.sv
// Serial DAC transmitter: accepts one sample per valid/ready handshake,
// shifts {CFG, data} MSB-first in SPI mode 0, then strobes LDAC low so the
// DAC output updates synchronously. All outputs come straight from flops.
module dac_tx
  import dac_tx_pkg::*;
#(
  parameter int         DATA_W   = 12,
  parameter logic [3:0] CFG      = CFG_DEFAULT,
  parameter int         SCK_HALF = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic              dac_clk,
  output logic              dac_cs,
  output logic              dac_sdi,
  output logic              dac_ldac
);

  localparam int              HC_W    = $clog2(SCK_HALF) + 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCK_HALF - 1);

  logic [STATE_W-1:0] state, state_next;
  logic [HC_W-1:0]    hc, hc_next;
  logic [3:0]         bc, bc_next;
  logic [FRAME_W-1:0] sr, sr_next;
  logic [FRAME_W-1:0] frame;
  logic               ready_next, done_next, clk_next, cs_next, ldac_next;
  logic               phase_end;

  assign frame     = {CFG, data};
  assign phase_end = (hc == HC_LAST);

  // The DAC samples the MSB of the shift register; shifting left while
  // dac_clk is low presents the next bit well before the next rising edge.
  assign dac_sdi = sr[FRAME_W-1];

  // Next-state and next-output logic for the whole frame sequence.
  always_comb begin
    state_next = state;
    hc_next    = hc;
    bc_next    = bc;
    sr_next    = sr;
    ready_next = ready;
    clk_next   = dac_clk;
    cs_next    = dac_cs;
    ldac_next  = dac_ldac;

    case (state)
      ST_IDLE: begin
        if (valid && ready) begin
          sr_next    = frame;
          cs_next    = 1'b0;
          clk_next   = 1'b0;
          bc_next    = 4'd0;
          hc_next    = '0;
          ready_next = 1'b0;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!phase_end) begin
          hc_next = hc + 1'b1;
        end else begin
          hc_next = '0;
          if (!dac_clk) begin
            clk_next = 1'b1;
          end else begin
            clk_next = 1'b0;
            if (bc != 4'd15) begin
              sr_next = {sr[FRAME_W-2:0], 1'b0};
              bc_next = bc + 4'd1;
            end else begin
              state_next = ST_HOLD;
            end
          end
        end
      end

      // Keep CS low for one more half period after the last falling edge.
      ST_HOLD: begin
        if (!phase_end) begin
          hc_next = hc + 1'b1;
        end else begin
          hc_next    = '0;
          cs_next    = 1'b1;
          ldac_next  = 1'b0;
          sr_next    = '0;
          state_next = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (!phase_end) begin
          hc_next = hc + 1'b1;
        end else begin
          hc_next    = '0;
          ldac_next  = 1'b1;
          state_next = ST_GAP;
        end
      end

      ST_GAP: begin
        if (!phase_end) begin
          hc_next = hc + 1'b1;
        end else begin
          hc_next    = '0;
          ready_next = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        hc_next    = '0;
        ready_next = 1'b1;
        clk_next   = 1'b0;
        cs_next    = 1'b1;
        ldac_next  = 1'b1;
        sr_next    = '0;
      end
    endcase

    // done marks the final LDAC-low cycle; looking at the next state keeps
    // this correct even when LATCH is a single cycle (SCK_HALF = 1).
    done_next = (state_next == ST_LATCH) && (hc_next == HC_LAST);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      hc       <= '0;
      bc       <= 4'd0;
      sr       <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      dac_clk  <= 1'b0;
      dac_cs   <= 1'b1;
      dac_ldac <= 1'b1;
    end else begin
      state    <= state_next;
      hc       <= hc_next;
      bc       <= bc_next;
      sr       <= sr_next;
      ready    <= ready_next;
      done     <= done_next;
      dac_clk  <= clk_next;
      dac_cs   <= cs_next;
      dac_ldac <= ldac_next;
    end
  end

endmodule

// File: tb/tb_dac_tx.sv
// Bench for dac_tx: one instance at SCK_HALF=5, one at SCK_HALF=1.
// A negedge monitor decodes the SPI pins into frames and timing runs;
// expected frames are {config nibble, sample} and expected run lengths
// follow from the half period H.
module tb_dac_tx;

  localparam logic [3:0] CFG_BITS = 4'b0011;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, done_a, dclk_a, cs_a, sdi_a, ldac_a;
  logic        ready_b, done_b, dclk_b, cs_b, sdi_b, ldac_b;

  logic [1:0]  ready_v, done_v, dclk_v, cs_v, sdi_v, ldac_v;
  assign ready_v = {ready_b, ready_a};
  assign done_v  = {done_b, done_a};
  assign dclk_v  = {dclk_b, dclk_a};
  assign cs_v    = {cs_b, cs_a};
  assign sdi_v   = {sdi_b, sdi_a};
  assign ldac_v  = {ldac_b, ldac_a};

  dac_tx #(.DATA_W(12), .CFG(CFG_BITS), .SCK_HALF(5)) u_dac_h5 (
    .clk(clk), .resetn(resetn), .data(data_a), .valid(valid_a),
    .ready(ready_a), .done(done_a), .dac_clk(dclk_a), .dac_cs(cs_a),
    .dac_sdi(sdi_a), .dac_ldac(ldac_a));

  dac_tx #(.DATA_W(12), .CFG(CFG_BITS), .SCK_HALF(1)) u_dac_h1 (
    .clk(clk), .resetn(resetn), .data(data_b), .valid(valid_b),
    .ready(ready_b), .done(done_b), .dac_clk(dclk_b), .dac_cs(cs_b),
    .dac_sdi(sdi_b), .dac_ldac(ldac_b));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- pin-level monitor ----------------
  typedef struct { int inst; logic [15:0] frame; int nbits; int cs_low; logic ldac_at_cs; } frame_rec_t;
  typedef struct { int inst; int len; logic done_last; } run_rec_t;

  frame_rec_t frame_q[$];
  run_rec_t   ldac_q[$];
  run_rec_t   rdy_q[$];
  int         gap_q[$];

  logic [15:0] cur [2];
  int nbits [2], cs_low [2], rdy_low [2], ldac_low [2], done_cnt [2], rise_cyc [2];
  logic prev_dclk [2], prev_cs [2], ldac_done_last [2];
  int cyc = 0;

  always @(negedge clk) begin
    frame_rec_t fr;
    run_rec_t   rr;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        cur[i] = '0; nbits[i] = 0; cs_low[i] = 0; rdy_low[i] = 0; ldac_low[i] = 0;
      end else begin
        if (dclk_v[i] && !prev_dclk[i] && !cs_v[i]) begin
          cur[i] = {cur[i][14:0], sdi_v[i]};
          nbits[i]++;
        end
        if (!cs_v[i]) begin
          if (prev_cs[i]) gap_q.push_back(cyc - rise_cyc[i]);
          cs_low[i]++;
        end else if (!prev_cs[i] && cs_low[i] != 0) begin
          fr.inst = i; fr.frame = cur[i]; fr.nbits = nbits[i];
          fr.cs_low = cs_low[i]; fr.ldac_at_cs = !ldac_v[i];
          frame_q.push_back(fr);
          cur[i] = '0; nbits[i] = 0; cs_low[i] = 0;
        end
        if (!ready_v[i]) begin
          rdy_low[i]++;
        end else begin
          if (rdy_low[i] != 0) begin
            rr.inst = i; rr.len = rdy_low[i]; rr.done_last = 1'b0;
            rdy_q.push_back(rr);
            rise_cyc[i] = cyc;
          end
          rdy_low[i] = 0;
        end
        if (!ldac_v[i]) begin
          ldac_low[i]++;
          ldac_done_last[i] = done_v[i];
        end else if (ldac_low[i] != 0) begin
          rr.inst = i; rr.len = ldac_low[i]; rr.done_last = ldac_done_last[i];
          ldac_q.push_back(rr);
          ldac_low[i] = 0;
        end
        if (done_v[i]) done_cnt[i]++;
      end
      prev_dclk[i] = dclk_v[i];
      prev_cs[i]   = cs_v[i];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_frame(input logic [11:0] d);
    return {CFG_BITS, d};
  endfunction

  // ---------------- helpers ----------------
  task automatic set_in(input int inst, input logic [11:0] d, input logic v);
    if (inst == 0) begin data_a = d; valid_a = v; end
    else begin data_b = d; valid_b = v; end
  endtask

  task automatic send(input int inst, input logic [11:0] d, input string tag);
    int n = 0;
    while (!ready_v[inst] && n < 2000) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready_before_send"}, (n < 2000) ? 1 : 0, 1);
    set_in(inst, d, 1'b1);
    @(posedge clk); #1;
    set_in(inst, $urandom, 1'b0);
  endtask

  task automatic wait_done(input int inst, input int target, input string tag);
    int n = 0;
    while ((done_cnt[inst] < target || !ready_v[inst]) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_completed"}, (n < 5000) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int inst, input int h, input logic [15:0] exp, input string tag);
    frame_rec_t f;
    run_rec_t   r;
    chk({tag, "_frame_seen"}, (frame_q.size() > 0) ? 1 : 0, 1);
    if (frame_q.size() > 0) begin
      f = frame_q.pop_front();
      chk({tag, "_inst"}, f.inst, inst);
      chk({tag, "_frame"}, f.frame, exp);
      chk({tag, "_bits"}, f.nbits, 16);
      chk({tag, "_cs_low_cycles"}, f.cs_low, 33 * h);
      chk({tag, "_ldac_low_at_cs_rise"}, f.ldac_at_cs, 1);
    end
    chk({tag, "_ldac_seen"}, (ldac_q.size() > 0) ? 1 : 0, 1);
    if (ldac_q.size() > 0) begin
      r = ldac_q.pop_front();
      chk({tag, "_ldac_low_cycles"}, r.len, h);
      chk({tag, "_done_in_last_ldac"}, r.done_last, 1);
    end
    chk({tag, "_ready_run_seen"}, (rdy_q.size() > 0) ? 1 : 0, 1);
    if (rdy_q.size() > 0) begin
      r = rdy_q.pop_front();
      chk({tag, "_ready_low_cycles"}, r.len, 35 * h);
    end
  endtask

  typedef struct packed { logic [11:0] d; logic [15:0] exp; logic disturb; } vec_t;
  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    int d0, n;
    logic [11:0] rd;

    vecs[0] = {12'hA5C, 16'h3A5C, 1'b1};
    vecs[1] = {12'h000, 16'h3000, 1'b0};
    vecs[2] = {12'hFFF, 16'h3FFF, 1'b0};
    vecs[3] = {12'h123, 16'h3123, 1'b0};
    vecs[4] = {12'h800, 16'h3800, 1'b0};
    vecs[5] = {12'h001, 16'h3001, 1'b0};

    resetn = 1'b0;
    data_a = '0; data_b = '0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready_%0d", i), ready_v[i], 1);
      chk($sformatf("reset_done_%0d", i), done_v[i], 0);
      chk($sformatf("reset_dac_clk_%0d", i), dclk_v[i], 0);
      chk($sformatf("reset_dac_cs_%0d", i), cs_v[i], 1);
      chk($sformatf("reset_dac_sdi_%0d", i), sdi_v[i], 0);
      chk($sformatf("reset_dac_ldac_%0d", i), ldac_v[i], 1);
    end
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table of single words on the H=5 instance.
    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt[0];
      send(0, vecs[k].d, $sformatf("vec%0d", k));
      if (vecs[k].disturb) begin
        repeat (10) @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) begin
          set_in(0, $urandom, j[0] ? 1'b0 : 1'b1);
          @(posedge clk); #1;
        end
        set_in(0, $urandom, 1'b0);
      end
      wait_done(0, d0 + 1, $sformatf("vec%0d", k));
      check_frame(0, 5, vecs[k].exp, $sformatf("vec%0d", k));
      if (vecs[k].disturb) begin
        repeat (200) @(posedge clk);
        #1;
        chk("stability_no_second_frame", frame_q.size(), 0);
        chk("stability_single_done", done_cnt[0] - d0, 1);
        chk("stability_cs_idle", cs_a, 1);
      end
    end

    // Back-to-back with valid held high.
    gap_q.delete();
    d0 = done_cnt[0];
    n = 0;
    while (!ready_a && n < 2000) begin @(posedge clk); #1; n++; end
    set_in(0, 12'h000, 1'b1);
    @(posedge clk); #1;
    set_in(0, 12'hFFF, 1'b1);
    n = 0;
    while (!ready_a && n < 2000) begin @(posedge clk); #1; n++; end
    chk("b2b_ready_returned", (n < 2000) ? 1 : 0, 1);
    @(posedge clk); #1;
    set_in(0, 12'h0, 1'b0);
    chk("b2b_second_accept_cs_low", cs_a, 0);
    chk("b2b_second_accept_ready_low", ready_a, 0);
    wait_done(0, d0 + 2, "b2b");
    repeat (50) @(posedge clk);
    #1;
    chk("b2b_done_pulses", done_cnt[0] - d0, 2);
    check_frame(0, 5, 16'h3000, "b2b_first");
    check_frame(0, 5, 16'h3FFF, "b2b_second");
    chk("b2b_gap_seen", (gap_q.size() > 0) ? 1 : 0, 1);
    if (gap_q.size() > 0) chk("b2b_cs_fall_after_ready", gap_q[gap_q.size() - 1], 1);

    // Mid-frame reset after bit 7 has been clocked.
    d0 = done_cnt[0];
    send(0, 12'hABC, "midrst");
    n = 0;
    while (nbits[0] < 8 && n < 1000) begin @(negedge clk); #1; n++; end
    chk("midrst_reached_bit7", nbits[0], 8);
    resetn = 1'b0;
    #1;
    chk("midrst_cs_high", cs_a, 1);
    chk("midrst_clk_low", dclk_a, 0);
    chk("midrst_ldac_high", ldac_a, 1);
    chk("midrst_ready_high", ready_a, 1);
    chk("midrst_done_low", done_a, 0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt[0] - d0, 0);
    chk("midrst_no_frame", frame_q.size(), 0);
    chk("midrst_no_ldac", ldac_q.size(), 0);
    rdy_q.delete();
    send(0, 12'h123, "after_rst");
    wait_done(0, d0 + 1, "after_rst");
    check_frame(0, 5, 16'h3123, "after_rst");

    // H=1 instance.
    d0 = done_cnt[1];
    send(1, 12'h555, "h1");
    wait_done(1, d0 + 1, "h1");
    check_frame(1, 1, 16'h3555, "h1");

    // Randomized words on both instances against the model.
    for (int k = 0; k < 4; k++) begin
      rd = 12'($urandom);
      d0 = done_cnt[0];
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      send(0, rd, $sformatf("rand_h5_%0d", k));
      wait_done(0, d0 + 1, $sformatf("rand_h5_%0d", k));
      check_frame(0, 5, model_frame(rd), $sformatf("rand_h5_%0d", k));
    end
    for (int k = 0; k < 10; k++) begin
      rd = 12'($urandom);
      d0 = done_cnt[1];
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(1, rd, $sformatf("rand_h1_%0d", k));
      wait_done(1, d0 + 1, $sformatf("rand_h1_%0d", k));
      check_frame(1, 1, model_frame(rd), $sformatf("rand_h1_%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
Name: dac_tx

Overview:
- Serial DAC transmitter that sends 12-bit samples to an MCP4921-style SPI DAC.
- It is the write-side counterpart of the existing serial ADC receiver and runs in the pixclk domain.
- Accepts one sample per valid/ready handshake, shifts a 16-bit command frame MSB-first in SPI mode 0, then pulses LDAC so the output updates synchronously.
- Intended for audio loop-back and test-tone output alongside the ADC/SDFT path.

Parameters:
- DATA_W, 12: sample width; the frame is {CFG, data}, FRAME_W = 16 bits.
- CFG, 4'b0011: config nibble (A/B=0, BUF=0, GA=1 for 1x gain, SHDN=1 for active).
- SCK_HALF, 5: pixclk cycles per dac_clk half-period (H); must be >= 1.

Ports:
- clk  in  1  pixclk.
- resetn  in  1  asynchronous active-low reset.
- data  in  DATA_W  sample to transmit.
- valid  in  1  data is valid.
- ready  out  1  block can accept a sample.
- done  out  1  single-cycle pulse when the DAC output has been latched.
- dac_clk  out  1  SPI clock; idles low.
- dac_cs  out  1  chip select, active low.
- dac_sdi  out  1  serial data to the DAC.
- dac_ldac  out  1  latch strobe, active low.

Behaviour:
- Reset (async assert, sync release): all outputs registered.
  - ready=1, done=0, dac_clk=0, dac_cs=1, dac_sdi=0, dac_ldac=1.
  - State IDLE; counters and shift register cleared.
- Handshake:
  - A transfer is accepted on the clk edge where valid && ready.
  - data is latched into shift register sr = {CFG, data}; later changes to data or valid are ignored.
  - ready is high only in IDLE and drops the cycle after accept.
- States: IDLE -> SHIFT -> HOLD -> LATCH -> GAP -> IDLE.
- A half-period counter hc (0..H-1) advances each cycle; a phase ends when hc == H-1. A bit counter bc (0..15) tracks bits.
- IDLE:
  - On accept: dac_cs=0, dac_clk=0, dac_sdi=sr[15], bc=0, hc=0; go to SHIFT.
- SHIFT:
  - Each bit spends H cycles with dac_clk=0, then H cycles with dac_clk=1.
  - At the end of a high phase with bc<15: dac_clk=0, shift sr left, dac_sdi=next MSB, bc++.
  - At the end of the high phase of bit 15: dac_clk=0, go to HOLD.
  - sdi changes only while dac_clk is low; the DAC samples on the rising edge.
  - SHIFT lasts exactly 32H cycles.
- HOLD:
  - H cycles with cs low and clk low (cs setup after the last edge).
  - Then dac_cs=1, dac_ldac=0; go to LATCH.
- LATCH:
  - dac_ldac low for H cycles; done=1 in the last of them.
  - Then dac_ldac=1; go to GAP.
- GAP:
  - H cycles with all idle levels.
  - Then ready=1; go to IDLE.
- Timing:
  - dac_cs is low for 33H cycles, starting one cycle after accept.
  - ready is low for 35H cycles (175 at H=5); maximum rate is one sample per 35H+1 cycles.
- Back-to-back: if valid is held high, the next accept occurs on the first cycle ready is high. There are no bubbles beyond that.
- valid while busy: ignored, no queueing; the upstream holds data.
- Reset mid-frame: outputs return immediately to reset values and the frame is aborted. No LDAC pulse is issued, so the DAC keeps its previous output.
- H=1 edge case: dac_clk toggles every cycle and all phases are one cycle.
- Widths:
  - hc is $clog2(SCK_HALF)+1 bits; bc is 4 bits.
  - No arithmetic on data; CFG is concatenated as-is.

Decomposition:
- Shared package holds:
  - FRAME_W=16.
  - MCP4921 config bit positions and default CFG.
  - State encoding localparams (IDLE, SHIFT, HOLD, LATCH, GAP).
- A half-period tick generator could be split out as a sub-module (sck_tick), but it stays inline. The block is a single module.

Test Plan:
- Reset: hold resetn=0 -> ready=1, dac_cs=1, dac_ldac=1, dac_clk=0, dac_sdi=0, done=0.
- Single word, H=5, data=12'hA5C: capture sdi on 16 rising dac_clk edges -> 16'h3A5C MSB-first.
  - dac_cs low for 165 cycles starting the cycle after accept.
  - dac_ldac low for 5 cycles right after cs rises, with done high in its last cycle.
  - ready low for 175 cycles.
- Data stability: change data and toggle valid during SHIFT -> transmitted frame is still 16'h3A5C; no second frame starts.
- Back-to-back: valid held high with 12'h000 then 12'hFFF -> frames 16'h3000 and 16'h3FFF.
  - Second dac_cs falls exactly 1 cycle after ready reasserts.
  - Exactly two done pulses.
- Mid-frame reset: assert resetn=0 after bit 7's rising edge -> same cycle: cs=1, clk=0, ldac=1.
  - No done pulse.
  - After release, a new word 12'h123 transmits correctly as 16'h3123.
- H=1, data=12'h555: dac_clk toggles every cycle -> 16'h3555 captured; ready low for 35 cycles.
